// File: rtl/mem_wb_stage.sv
// Memory-access stage and MEM/WB pipeline register.
// Little-endian byte/half/word loads and stores against an internal word-organised data memory.
module mem_wb_stage #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        valid_in,
  input  logic [31:0] ALU_result_in,
  input  logic [31:0] store_data_in,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic        mem_to_reg_in,
  input  logic        reg_write_in,
  input  logic [4:0]  rd_in,
  output logic [31:0] read_data,
  output logic [31:0] ALU_result,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic [4:0]  rd,
  output logic        valid_out,
  output logic        fault
);

  logic [31:0] mem [DEPTH_WORDS];

  logic [ADDR_W-1:0] widx;
  logic [1:0]        lane;
  logic              access;
  logic              fault_c;
  logic [31:0]       rdata_c;
  logic [31:0]       wdata_c;
  logic [3:0]        be_c;
  logic              we_c;

  logic [31:0] read_data_p1;
  logic [31:0] alu_p1;
  logic        mem_to_reg_p1;
  logic        reg_write_p1;
  logic [4:0]  rd_p1;
  logic        vld_p1;
  logic        fault_p1;

  function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] ln);
    logic [31:0] s;
    s = w >> {ln, 3'b000};
    case (f3)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b010:  return s;
      3'b100:  return {24'd0, s[7:0]};
      3'b101:  return {16'd0, s[15:0]};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic access_fault(input logic rd_en, input logic wr_en,
                                        input logic [2:0] f3, input logic [1:0] ln);
    if (rd_en && wr_en) return 1'b1;
    case (f3)
      3'b000:  return 1'b0;
      3'b001:  return ln[0];
      3'b010:  return ln != 2'b00;
      3'b100:  return wr_en;
      3'b101:  return wr_en | ln[0];
      default: return 1'b1;
    endcase
  endfunction

  assign widx   = ALU_result_in[ADDR_W+1:2];
  assign lane   = ALU_result_in[1:0];
  assign access = valid_in & (mem_read | mem_write);

  always_comb begin
    fault_c = 1'b0;
    rdata_c = 32'd0;
    wdata_c = store_data_in;
    be_c    = 4'b0000;
    if (access) fault_c = access_fault(mem_read, mem_write, funct3, lane);
    if (access && mem_read && !fault_c) rdata_c = fmt_load(mem[widx], funct3, lane);
    // Replicate the low byte/half across the word so the byte enables pick the lane.
    case (funct3)
      3'b000: begin
        wdata_c = {4{store_data_in[7:0]}};
        be_c    = 4'b0001 << lane;
      end
      3'b001: begin
        wdata_c = {2{store_data_in[15:0]}};
        be_c    = 4'b0011 << lane;
      end
      3'b010:  be_c = 4'b1111;
      default: be_c = 4'b0000;
    endcase
  end

  assign we_c = access & mem_write & ~fault_c & ~rst & ~flush & ~stall;

  always_ff @(posedge clk) begin
    if (we_c) begin
      for (int i = 0; i < 4; i++) begin
        if (be_c[i]) mem[widx][8*i +: 8] <= wdata_c[8*i +: 8];
      end
    end
  end

  // MEM -> WB register boundary
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      read_data_p1  <= 32'd0;
      alu_p1        <= 32'd0;
      mem_to_reg_p1 <= 1'b0;
      reg_write_p1  <= 1'b0;
      rd_p1         <= 5'd0;
      vld_p1        <= 1'b0;
      fault_p1      <= 1'b0;
    end else if (!stall) begin
      read_data_p1  <= rdata_c;
      alu_p1        <= ALU_result_in;
      mem_to_reg_p1 <= mem_to_reg_in;
      reg_write_p1  <= reg_write_in & ~fault_c;
      rd_p1         <= rd_in;
      vld_p1        <= valid_in;
      fault_p1      <= fault_c;
    end
  end

  assign read_data  = read_data_p1;
  assign ALU_result = alu_p1;
  assign mem_to_reg = mem_to_reg_p1;
  assign reg_write  = reg_write_p1;
  assign rd         = rd_p1;
  assign valid_out  = vld_p1;
  assign fault      = fault_p1;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush, valid_in;
  logic [31:0] ALU_result_in, store_data_in;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic        mem_to_reg_in, reg_write_in;
  logic [4:0]  rd_in;
  logic [31:0] read_data, ALU_result;
  logic        mem_to_reg, reg_write, valid_out, fault;
  logic [4:0]  rd;

  int checks = 0;
  int errors = 0;

  mem_wb_stage #(.DEPTH_WORDS(1024), .ADDR_W(10)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in),
    .ALU_result_in(ALU_result_in), .store_data_in(store_data_in),
    .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .mem_to_reg_in(mem_to_reg_in), .reg_write_in(reg_write_in), .rd_in(rd_in),
    .read_data(read_data), .ALU_result(ALU_result), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .rd(rd), .valid_out(valid_out), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic op(input logic v, input logic r, input logic w, input logic [2:0] f3,
                    input logic [31:0] addr, input logic [31:0] data,
                    input logic st, input logic fl, input logic m2r, input logic rw);
    valid_in = v; mem_read = r; mem_write = w; funct3 = f3;
    ALU_result_in = addr; store_data_in = data;
    stall = st; flush = fl; mem_to_reg_in = m2r; reg_write_in = rw; rd_in = 5'd9;
    @(posedge clk); #1;
  endtask

  task automatic ld(input logic [31:0] addr, input logic [2:0] f3);
    op(1'b1, 1'b1, 1'b0, f3, addr, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic sto(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] f3);
    op(1'b1, 1'b0, 1'b1, f3, addr, data, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_fault(input string tag);
    chk({tag, "_fault"}, {31'd0, fault}, 32'd1);
    chk({tag, "_rw"}, {31'd0, reg_write}, 32'd0);
    chk({tag, "_rdata"}, read_data, 32'd0);
    chk({tag, "_vld"}, {31'd0, valid_out}, 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      stall = 1'b0; flush = 1'b0; valid_in = 1'($urandom);
      ALU_result_in = $urandom; store_data_in = $urandom;
      mem_read = 1'($urandom); mem_write = 1'($urandom); funct3 = 3'($urandom);
      mem_to_reg_in = 1'($urandom); reg_write_in = 1'($urandom); rd_in = 5'($urandom);
      @(posedge clk); #1;
    end
    chk("rst_rdata", read_data, 32'd0);
    chk("rst_alu", ALU_result, 32'd0);
    chk("rst_m2r", {31'd0, mem_to_reg}, 32'd0);
    chk("rst_rw", {31'd0, reg_write}, 32'd0);
    chk("rst_rd", {27'd0, rd}, 32'd0);
    chk("rst_vld", {31'd0, valid_out}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    rst = 1'b0;

    sto(32'h10, 32'hDEADBEEF, 3'b010);
    chk("sw_fault", {31'd0, fault}, 32'd0);
    chk("sw_vld", {31'd0, valid_out}, 32'd1);
    ld(32'h10, 3'b010);
    chk("lw_data", read_data, 32'hDEADBEEF);
    chk("lw_m2r", {31'd0, mem_to_reg}, 32'd1);
    chk("lw_rw", {31'd0, reg_write}, 32'd1);
    chk("lw_fault", {31'd0, fault}, 32'd0);
    chk("lw_rd", {27'd0, rd}, 32'd9);
    chk("lw_alu", ALU_result, 32'h10);

    sto(32'h20, 32'h80FF7F01, 3'b010);
    ld(32'h21, 3'b000); chk("lb_21", read_data, 32'h0000007F);
    ld(32'h23, 3'b000); chk("lb_23", read_data, 32'hFFFFFF80);
    ld(32'h23, 3'b100); chk("lbu_23", read_data, 32'h00000080);
    ld(32'h22, 3'b001); chk("lh_22", read_data, 32'hFFFF80FF);
    ld(32'h22, 3'b101); chk("lhu_22", read_data, 32'h000080FF);
    ld(32'h20, 3'b101); chk("lhu_20", read_data, 32'h00007F01);

    sto(32'h30, 32'hFFFFFFFF, 3'b010);
    sto(32'h31, 32'hAAAAAA12, 3'b000);
    sto(32'h32, 32'h5555ABCD, 3'b001);
    ld(32'h30, 3'b010); chk("sb_sh_merge", read_data, 32'hABCD12FF);

    ld(32'h31, 3'b010); chk_fault("lw_mis");
    chk("lw_mis_alu", ALU_result, 32'h31);
    op(1'b1, 1'b0, 1'b1, 3'b001, 32'h33, 32'h00009999, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_fault("sh_mis");
    ld(32'h30, 3'b011); chk_fault("f3_011");
    op(1'b1, 1'b1, 1'b1, 3'b010, 32'h30, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b1);
    chk_fault("rd_wr");
    ld(32'h30, 3'b010); chk("mis_nowrite", read_data, 32'hABCD12FF);
    chk("mis_clear", {31'd0, fault}, 32'd0);

    sto(32'h40, 32'h11111111, 3'b010);
    ld(32'h10, 3'b010);
    op(1'b1, 1'b0, 1'b1, 3'b010, 32'h40, 32'h00000055, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("stall_rdata", read_data, 32'hDEADBEEF);
    chk("stall_alu", ALU_result, 32'h10);
    chk("stall_rw", {31'd0, reg_write}, 32'd1);
    ld(32'h40, 3'b010); chk("stall_nowrite", read_data, 32'h11111111);
    op(1'b1, 1'b0, 1'b1, 3'b010, 32'h40, 32'h00000055, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("flush_vld", {31'd0, valid_out}, 32'd0);
    chk("flush_rw", {31'd0, reg_write}, 32'd0);
    chk("flush_rdata", read_data, 32'd0);
    ld(32'h40, 3'b010); chk("flush_nowrite", read_data, 32'h11111111);

    sto(32'h1008, 32'h00001234, 3'b010);
    ld(32'h8, 3'b010); chk("wrap", read_data, 32'h00001234);
    op(1'b0, 1'b0, 1'b1, 3'b010, 32'h8, 32'h00009999, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("inv_fault", {31'd0, fault}, 32'd0);
    chk("inv_vld", {31'd0, valid_out}, 32'd0);
    chk("inv_rw", {31'd0, reg_write}, 32'd1);
    ld(32'h8, 3'b010); chk("inv_nowrite", read_data, 32'h00001234);

    op(1'b0, 1'b1, 1'b0, 3'b010, 32'h8, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("inv_load_rdata", read_data, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
